// File: rtl/if_fetch_queue.sv
// rtl/if_fetch_queue.sv - instruction fetch stage: PC select, imem req/ack port, {pc,inst} fetch queue
module if_fetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              QDEPTH   = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0010
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    pc_write,
    input  logic [1:0]              pc_src,
    input  logic [XLEN-1:0]         beq,
    input  logic [XLEN-1:0]         jr,
    input  logic [XLEN-29:0]        pc_4_id,
    input  logic [27:0]             offset28,
    output logic                    imem_req,
    output logic [XLEN-1:0]         imem_addr,
    input  logic                    imem_ack,
    input  logic [XLEN-1:0]         imem_rdata,
    output logic                    inst_valid,
    input  logic                    id_ready,
    output logic [XLEN-1:0]         inst_out,
    output logic [XLEN-1:0]         pc_out,
    output logic [XLEN-1:0]         pc_4_out,
    output logic [$clog2(QDEPTH):0] fq_count,
    output logic                    misalign
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(QDEPTH);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DROP} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] drop_addr_q, drop_addr_d;
    logic            misalign_q, misalign_d;
    logic [PW-1:0]   wptr_q, wptr_d;
    logic [PW-1:0]   rptr_q, rptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [XLEN-1:0] mem_pc_q [QDEPTH];
    logic [XLEN-1:0] mem_pc_d [QDEPTH];
    logic [XLEN-1:0] mem_inst_q [QDEPTH];
    logic [XLEN-1:0] mem_inst_d [QDEPTH];

    logic            redirect;
    logic [XLEN-1:0] target_raw;
    logic            push;
    logic            pop;
    logic [CW-1:0]   count_after;

    always_comb begin
        redirect = (pc_src != 2'b00);
        case (pc_src)
            2'b01:   target_raw = {pc_4_id, offset28};
            2'b10:   target_raw = beq;
            2'b11:   target_raw = jr;
            default: target_raw = fetch_pc_q;
        endcase
    end

    // Fetch FSM; a redirect overrides any push/pop and retargets fetch_pc
    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        drop_addr_d = drop_addr_q;
        misalign_d  = redirect && (target_raw[1:0] != 2'b00);
        push        = 1'b0;
        pop         = id_ready && (count_q != '0) && !redirect;
        count_after = count_q + CW'(1) - CW'(pop);

        case (state_q)
            S_IDLE: begin
                if (pc_write && (count_q < FULL) && !redirect) begin
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (redirect) begin
                    state_d     = imem_ack ? S_IDLE : S_DROP;
                    drop_addr_d = fetch_pc_q;
                end else if (imem_ack) begin
                    push       = 1'b1;
                    fetch_pc_d = fetch_pc_q + XLEN'(4);
                    state_d    = (pc_write && (count_after < FULL)) ? S_BUSY : S_IDLE;
                end
            end
            S_DROP: begin
                if (imem_ack) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (redirect) begin
            fetch_pc_d = {target_raw[XLEN-1:2], 2'b00};
        end
    end

    always_comb begin
        mem_pc_d   = mem_pc_q;
        mem_inst_d = mem_inst_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        if (redirect) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                mem_pc_d[wptr_q]   = fetch_pc_q;
                mem_inst_d[wptr_q] = imem_rdata;
                wptr_d             = wptr_q + PW'(1);
            end
            if (pop) begin
                rptr_d = rptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            fetch_pc_q  <= RESET_PC;
            drop_addr_q <= '0;
            misalign_q  <= 1'b0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                mem_pc_q[i]   <= '0;
                mem_inst_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            drop_addr_q <= drop_addr_d;
            misalign_q  <= misalign_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            mem_pc_q    <= mem_pc_d;
            mem_inst_q  <= mem_inst_d;
        end
    end

    // DROP keeps presenting the abandoned address until memory answers it
    assign imem_req   = (state_q != S_IDLE);
    assign imem_addr  = (state_q == S_DROP) ? drop_addr_q : fetch_pc_q;
    assign inst_valid = (count_q != '0);
    assign inst_out   = mem_inst_q[rptr_q];
    assign pc_out     = mem_pc_q[rptr_q];
    assign pc_4_out   = mem_pc_q[rptr_q] + XLEN'(4);
    assign fq_count   = count_q;
    assign misalign   = misalign_q;

endmodule
